// File: rtl/alu_sequencer.sv
// Fetch/decode/control stage for the 4-bit processor: sequences instructions from a
// synchronous program memory, drives the ALU over a fixed-latency window, and writes results back.
module alu_sequencer #(
    parameter int PC_W    = 4,
    parameter int ALU_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd_en,
    input  logic [7:0]      imem_data,
    output logic [3:0]      alu_opcode,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    input  logic [3:0]      alu_result,
    input  logic [4:0]      alu_flag,
    output logic [3:0]      acc_out,
    output logic [4:0]      flags_out,
    output logic [PC_W-1:0] pc_out,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_WB, S_HALTED
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_CMP = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b0111;
    localparam logic [3:0] OP_JMP = 4'b1000;
    localparam logic [3:0] OP_JEQ = 4'b1001;
    localparam logic [3:0] OP_JLT = 4'b1010;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

    state_t          r_state, w_state_next;
    logic [PC_W-1:0] r_pc, w_pc_next;
    logic [3:0]      r_acc, w_acc_next;
    logic [4:0]      r_flags, w_flags_next;
    logic [7:0]      r_ir, w_ir_next;
    logic [2:0]      r_cnt, w_cnt_next;

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_imm_pc;
    logic [3:0]      w_dec_op;
    logic [3:0]      w_dec_imm;

    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_dec_op  = imem_data[7:4];
    assign w_dec_imm = imem_data[3:0];
    assign w_imm_pc  = PC_W'(w_dec_imm);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_acc   <= '0;
            r_flags <= '0;
            r_ir    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_acc   <= w_acc_next;
            r_flags <= w_flags_next;
            r_ir    <= w_ir_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_acc_next   = r_acc;
        w_flags_next = r_flags;
        w_ir_next    = r_ir;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FETCH;
                    w_pc_next    = '0;
                end
            end
            S_FETCH: w_state_next = S_WAIT;
            S_WAIT:  w_state_next = S_DECODE;
            S_DECODE: begin
                // Non-ALU instructions resolve from the memory word directly, as ir is
                // only being loaded on this same edge.
                w_ir_next    = imem_data;
                w_state_next = S_FETCH;
                w_pc_next    = w_pc_inc;
                case (w_dec_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
                        w_state_next = S_EXEC;
                        w_pc_next    = r_pc;
                        w_cnt_next   = '0;
                    end
                    OP_LDI: w_acc_next = w_dec_imm;
                    OP_JMP: w_pc_next  = w_imm_pc;
                    OP_JEQ: w_pc_next  = r_flags[2] ? w_imm_pc : w_pc_inc;
                    OP_JLT: w_pc_next  = r_flags[4] ? w_imm_pc : w_pc_inc;
                    OP_HLT: begin
                        w_state_next = S_HALTED;
                        w_pc_next    = r_pc;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                if (r_cnt == LAT_LAST) begin
                    w_state_next = S_WB;
                end else begin
                    w_cnt_next = r_cnt + 3'd1;
                end
            end
            S_WB: begin
                if (r_ir[7:4] != OP_CMP) begin
                    w_acc_next = alu_result;
                end
                w_flags_next = alu_flag;
                w_pc_next    = w_pc_inc;
                w_state_next = S_FETCH;
            end
            S_HALTED: w_state_next = S_HALTED;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ALU inputs are only presented during the EXEC window; zero elsewhere.
    assign alu_opcode = (r_state == S_EXEC) ? r_ir[7:4] : 4'b0000;
    assign alu_a      = (r_state == S_EXEC) ? r_acc : 4'b0000;
    assign alu_b      = (r_state == S_EXEC) ? r_ir[3:0] : 4'b0000;
    assign imem_rd_en = (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign acc_out    = r_acc;
    assign flags_out  = r_flags;
    assign pc_out     = r_pc;
    assign busy       = (r_state != S_IDLE) && (r_state != S_HALTED);
    assign halted     = (r_state == S_HALTED);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural program memory and ALU, plus an instruction-level
// reference interpreter checked at every instruction boundary.
module tb_alu_sequencer;
    localparam int PC_W = 4;
    parameter int LAT = 2;

    logic            clk;
    logic            reset;
    logic            start;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rd_en;
    logic [7:0]      imem_data;
    logic [3:0]      alu_opcode, alu_a, alu_b, alu_result;
    logic [4:0]      alu_flag;
    logic [3:0]      acc_out;
    logic [4:0]      flags_out;
    logic [PC_W-1:0] pc_out;
    logic            busy, halted;

    int total = 0;
    int bad = 0;

    alu_sequencer #(.PC_W(PC_W), .ALU_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_data(imem_data),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flag(alu_flag),
        .acc_out(acc_out), .flags_out(flags_out), .pc_out(pc_out),
        .busy(busy), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {less, greater, equal, carry, borrow, result}
    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, bo;
        s = {1'b0, a} + {1'b0, b};
        c = 1'b0;
        bo = 1'b0;
        case (op)
            4'd1: begin r = s[3:0]; c = s[4]; end
            4'd2, 4'd6: begin r = a - b; bo = (a < b); end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            default: r = 4'd0;
        endcase
        return {a < b, a > b, a == b, c, bo, r};
    endfunction

    logic [7:0] prog [16];
    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= prog[imem_addr];
    end

    logic [8:0] alu_pipe [LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_fn(alu_opcode, alu_a, alu_b);
        for (int k = 1; k < LAT; k++) alu_pipe[k] <= alu_pipe[k-1];
    end
    assign {alu_flag, alu_result} = alu_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Instruction-level reference state
    logic [PC_W-1:0] m_pc;
    logic [3:0]      m_acc;
    logic [4:0]      m_flags;
    bit              m_halted;

    task automatic model_step(output int cyc, output int exec_n, output logic [11:0] exp_ops);
        logic [7:0] ins;
        logic [3:0] op, imm;
        logic [8:0] res;
        ins = prog[m_pc];
        op = ins[7:4];
        imm = ins[3:0];
        cyc = 3;
        exec_n = 0;
        exp_ops = '0;
        if (op >= 4'd1 && op <= 4'd6) begin
            res = alu_fn(op, m_acc, imm);
            exp_ops = {op, m_acc, imm};
            if (op != 4'd6) m_acc = res[3:0];
            m_flags = res[8:4];
            m_pc = m_pc + 1;
            cyc = 4 + LAT;
            exec_n = LAT;
        end else if (op == 4'd7) begin
            m_acc = imm; m_pc = m_pc + 1;
        end else if (op == 4'd8) begin
            m_pc = PC_W'(imm);
        end else if (op == 4'd9) begin
            m_pc = m_flags[2] ? PC_W'(imm) : m_pc + 1;
        end else if (op == 4'd10) begin
            m_pc = m_flags[4] ? PC_W'(imm) : m_pc + 1;
        end else if (op == 4'd15) begin
            m_halted = 1;
        end else begin
            m_pc = m_pc + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        m_acc = '0;
        m_flags = '0;
        m_halted = 0;
        m_pc = '0;
    endtask

    task automatic run_prog(input string name, input int max_instr, input bit mid_start);
        int cyc, exec_n, nz, match, fetch_ok, n;
        logic [11:0] exp_ops;
        logic [PC_W-1:0] pc_before;
        do_reset();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < max_instr && !m_halted) begin
            pc_before = m_pc;
            model_step(cyc, exec_n, exp_ops);
            nz = 0; match = 0; fetch_ok = 0;
            for (int c = 0; c < cyc; c++) begin
                @(negedge clk);
                start = mid_start && (c == 1);
                if (alu_opcode != 4'd0) begin
                    nz++;
                    if ({alu_opcode, alu_a, alu_b} == exp_ops) match++;
                end
                if (imem_rd_en && imem_addr == pc_before) fetch_ok++;
            end
            @(posedge clk);
            #1;
            chk({name, "_fetch"}, fetch_ok, 1);
            chk({name, "_exec_len"}, nz, exec_n);
            chk({name, "_exec_ops"}, match, exec_n);
            chk({name, "_pc"}, pc_out, m_pc);
            chk({name, "_acc"}, acc_out, m_acc);
            chk({name, "_flags"}, flags_out, m_flags);
            chk({name, "_halted"}, halted, m_halted);
            chk({name, "_busy"}, busy, !m_halted);
            n++;
        end
        if (m_halted) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            repeat (3) @(negedge clk);
            chk({name, "_sticky"}, {halted, busy}, 2'b10);
            chk({name, "_sticky_pc"}, pc_out, m_pc);
        end
        start = 1'b0;
        $display("prog %s: instrs=%0d pc=%0d acc=%h flags=%b halted=%0d", name, n, pc_out, acc_out, flags_out, halted);
    endtask

    task automatic load(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                        input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
                        input logic [7:0] p6);
        for (int i = 0; i < 16; i++) prog[i] = 8'hF0;
        prog[0] = p0; prog[1] = p1; prog[2] = p2; prog[3] = p3;
        prog[4] = p4; prog[5] = p5; prog[6] = p6;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 16; i++) prog[i] = 8'hF0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", {acc_out, flags_out, pc_out, alu_opcode, alu_a, alu_b, imem_rd_en, busy, halted}, 0);
        reset = 1'b1;

        // Reset asserted in the middle of the ADD execute window
        load(8'h75, 8'h13, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_exec_op", {busy, alu_opcode, alu_a, alu_b}, {1'b1, 4'd1, 4'd5, 4'd3});
        reset = 1'b0;
        #1;
        chk("mid_rst_outs", {acc_out, flags_out, pc_out, alu_opcode, alu_a, alu_b, imem_rd_en, busy, halted}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", {acc_out, pc_out, busy, halted, imem_rd_en}, 0);

        load(8'h75, 8'h13, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
        run_prog("add", 10, 0);
        chk("add_final", {acc_out, flags_out[1], halted, pc_out}, {4'h8, 1'b0, 1'b1, 4'd2});

        load(8'h7F, 8'h11, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
        run_prog("carry", 10, 0);
        chk("carry_final", {acc_out, flags_out[1]}, {4'h0, 1'b1});

        load(8'h72, 8'h23, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
        run_prog("borrow", 10, 0);
        chk("borrow_final", {acc_out, flags_out[0]}, {4'hF, 1'b1});

        load(8'h77, 8'h67, 8'h95, 8'h71, 8'hF0, 8'h79, 8'hF0);
        run_prog("cmp_jeq", 10, 0);
        chk("cmp_jeq_final", {acc_out, flags_out[2], halted, pc_out}, {4'h9, 1'b1, 1'b1, 4'd6});

        load(8'h7A, 8'h55, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
        run_prog("xor", 10, 0);
        chk("xor_final", acc_out, 4'hF);

        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[15] = 8'h80;
        run_prog("loop", 40, 1);
        chk("loop_final", {pc_out, halted}, {4'd8, 1'b0});

        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        run_prog("wrap", 20, 0);
        chk("wrap_final", pc_out, 4'd4);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
            run_prog($sformatf("rand%0d", r), 40, r[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
